// File: rtl/atax_launcher_pkg.sv
// Shared types and constants for the atax batch launcher.
package atax_launcher_pkg;

  localparam int unsigned PTR_W     = 64;
  localparam int unsigned REC_IDX_W = 16;
  localparam int unsigned REC_LAT_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // One result record as seen downstream, at the default index/latency widths.
  typedef struct packed {
    logic [REC_IDX_W-1:0] index;
    logic [REC_LAT_W-1:0] latency;
  } res_rec_t;

endpackage

// File: rtl/atax_launcher_if.sv
// Host-facing and component-facing signal bundle of the atax launcher.
interface atax_launcher_if
  import atax_launcher_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT_W = 32
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PTR_W-1:0] cfg_a_base;
  logic [PTR_W-1:0] cfg_x_base;
  logic [PTR_W-1:0] cfg_y_base;
  logic [PTR_W-1:0] cfg_stride;
  logic [CNT_W-1:0] cfg_count;

  logic             comp_start;
  logic             comp_busy;
  logic [PTR_W-1:0] comp_A;
  logic [PTR_W-1:0] comp_x;
  logic [PTR_W-1:0] comp_y_out;
  logic             comp_done;
  logic             comp_stall;

  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_index;
  logic [LAT_W-1:0] res_latency;

  logic             running;
  logic             batch_done;
  logic             err_spurious;

  // Environment side: host front end, atax component and result sink.
  modport master (
    output cfg_valid, cfg_a_base, cfg_x_base, cfg_y_base, cfg_stride, cfg_count,
    output comp_busy, comp_done, res_ready,
    input  cfg_ready, comp_start, comp_A, comp_x, comp_y_out, comp_stall,
    input  res_valid, res_index, res_latency, running, batch_done, err_spurious
  );

  // Launcher side.
  modport slave (
    input  cfg_valid, cfg_a_base, cfg_x_base, cfg_y_base, cfg_stride, cfg_count,
    input  comp_busy, comp_done, res_ready,
    output cfg_ready, comp_start, comp_A, comp_x, comp_y_out, comp_stall,
    output res_valid, res_index, res_latency, running, batch_done, err_spurious
  );

endinterface

// File: rtl/atax_ts_fifo.sv
// Start-timestamp FIFO; its occupancy is the number of invocations in flight.
module atax_ts_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state: write on push, advance pointers, track occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = wdata_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop_i) begin
      rd_d = ptr_inc(rd_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/atax_launcher.sv
// Batch sequencer: issues cfg_count atax calls with strided pointers and
// reports one {index, latency} record per returned call.
module atax_launcher
  import atax_launcher_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LAT_W        = 32
) (
  input logic           clock,
  input logic           reset,
  atax_launcher_if.slave bus
);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] a_q, a_d, x_q, x_d, y_q, y_d, stride_q, stride_d;
  logic [CNT_W-1:0] count_q, count_d, issued_q, issued_d, returned_q, returned_d;
  logic [CNT_W-1:0] res_index_q, res_index_d;
  logic [LAT_W-1:0] res_latency_q, res_latency_d, cycle_q, cycle_d;
  logic             res_valid_q, res_valid_d, cfg_ready_q, cfg_ready_d, err_q, err_d;

  logic             cfg_acc, start, start_acc, stall, done_acc;
  logic             ts_full, ts_empty;
  logic [LAT_W-1:0] ts_head;

  // Handshake decode; FIFO occupancy doubles as the in-flight count.
  always_comb begin
    cfg_acc   = bus.cfg_valid && cfg_ready_q;
    start     = (state_q == StIssue) && (issued_q != count_q) && !ts_full;
    start_acc = start && !bus.comp_busy;
    stall     = res_valid_q && !bus.res_ready;
    done_acc  = bus.comp_done && !stall && !ts_empty;
  end

  atax_ts_fifo #(
    .Depth (MAX_INFLIGHT),
    .Width (LAT_W)
  ) u_ts_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (start_acc),
    .wdata_i (cycle_q),
    .pop_i   (done_acc),
    .rdata_o (ts_head),
    .full_o  (ts_full),
    .empty_o (ts_empty)
  );

  // Next-state for FSM, pointers, counters and the single result record.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    x_d           = x_q;
    y_d           = y_q;
    stride_d      = stride_q;
    count_d       = count_q;
    issued_d      = issued_q;
    returned_d    = returned_q;
    res_index_d   = res_index_q;
    res_latency_d = res_latency_q;
    res_valid_d   = res_valid_q;
    err_d         = err_q || (bus.comp_done && ts_empty);
    cycle_d       = cycle_q + LAT_W'(1);

    if (start_acc) begin
      a_d      = a_q + stride_q;
      x_d      = x_q + stride_q;
      y_d      = y_q + stride_q;
      issued_d = issued_q + CNT_W'(1);
    end

    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    // A new record may replace one that is being consumed this same cycle.
    if (done_acc) begin
      res_valid_d   = 1'b1;
      res_index_d   = returned_q;
      res_latency_d = cycle_q - ts_head;
      returned_d    = returned_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_acc) begin
          a_d        = bus.cfg_a_base;
          x_d        = bus.cfg_x_base;
          y_d        = bus.cfg_y_base;
          stride_d   = bus.cfg_stride;
          count_d    = bus.cfg_count;
          issued_d   = '0;
          returned_d = '0;
          state_d    = (bus.cfg_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: if (issued_q == count_q) state_d = StDrain;
      // Look at next-cycle values so batch_done follows the last handshake directly.
      StDrain: if ((returned_d == count_q) && !res_valid_d) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cfg_ready_d = (state_d == StIdle);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      a_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      stride_q      <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      returned_q    <= '0;
      res_index_q   <= '0;
      res_latency_q <= '0;
      res_valid_q   <= 1'b0;
      cfg_ready_q   <= 1'b0;
      err_q         <= 1'b0;
      cycle_q       <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      x_q           <= x_d;
      y_q           <= y_d;
      stride_q      <= stride_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      res_index_q   <= res_index_d;
      res_latency_q <= res_latency_d;
      res_valid_q   <= res_valid_d;
      cfg_ready_q   <= cfg_ready_d;
      err_q         <= err_d;
      cycle_q       <= cycle_d;
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.comp_start   = start;
  assign bus.comp_A       = a_q;
  assign bus.comp_x       = x_q;
  assign bus.comp_y_out   = y_q;
  assign bus.comp_stall   = stall;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_index    = res_index_q;
  assign bus.res_latency  = res_latency_q;
  assign bus.running      = (state_q != StIdle);
  assign bus.batch_done   = (state_q == StDone);
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_atax_launcher.sv
// Bench for atax_launcher: table of batch scenarios plus random batches,
// scored against a queue-based model of the component and result stream.
module tb_atax_launcher;
  import atax_launcher_pkg::*;

  localparam int unsigned MaxInflight = 2;
  localparam int unsigned CntW        = 16;
  localparam int unsigned LatW        = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  atax_launcher_if #(.CNT_W(CntW), .LAT_W(LatW)) bus ();

  atax_launcher #(
    .MAX_INFLIGHT (MaxInflight),
    .CNT_W        (CntW),
    .LAT_W        (LatW)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] a, x, y, s;
    int          cnt, lat_lo, lat_hi, busy_pct, busy_hold, ready_div;
    int          exp_nrec;
    logic [63:0] exp_last_a;
    int          exp_lat;   // 0: latency varies, not compared to a constant
    bit          exp_stall;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 0);
    check({tag, "_comp_start"}, bus.comp_start, 0);
    check({tag, "_comp_A"}, bus.comp_A, 0);
    check({tag, "_comp_x"}, bus.comp_x, 0);
    check({tag, "_comp_y"}, bus.comp_y_out, 0);
    check({tag, "_comp_stall"}, bus.comp_stall, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_index"}, bus.res_index, 0);
    check({tag, "_res_latency"}, bus.res_latency, 0);
    check({tag, "_running"}, bus.running, 0);
    check({tag, "_batch_done"}, bus.batch_done, 0);
    check({tag, "_err"}, bus.err_spurious, 0);
  endtask

  task automatic wait_cfg_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cfg_ready_wait"}, bus.cfg_ready, 1);
  endtask

  // Drives one batch, models the component (in-order returns after a per-call
  // delay) and scores every argument and record against that model.
  task automatic run_batch(input vec_t v, output int n_rec, output logic [63:0] last_a,
                           output int max_out, output int lat_min, output int lat_max,
                           output bit stall_seen);
    int       st_q[$];
    int       lat_q[$];
    res_rec_t exp_q[$];
    res_rec_t want;
    int       issued = 0, returned = 0, it = 0;
    bit       fin = 0, seen_bd = 0;
    n_rec = 0; last_a = '0; max_out = 0; lat_min = 32'h7fff_ffff; lat_max = 0;
    stall_seen = 0;

    wait_cfg_ready("batch");
    bus.cfg_a_base = v.a;
    bus.cfg_x_base = v.x;
    bus.cfg_y_base = v.y;
    bus.cfg_stride = v.s;
    bus.cfg_count  = CntW'(v.cnt);
    bus.cfg_valid  = 1'b1;
    bus.comp_busy  = 1'b0;
    bus.comp_done  = 1'b0;
    bus.res_ready  = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;

    while (!fin && it < 4000) begin
      bus.comp_busy = (it < v.busy_hold) || ($urandom_range(99) < v.busy_pct);
      bus.comp_done = (st_q.size() > 0) && (cyc >= st_q[0] + lat_q[0]);
      bus.res_ready = (v.ready_div > 0) ? ((cyc % v.ready_div) == 0) : ($urandom_range(1) == 1);
      #1;
      if (it < v.busy_hold) begin
        check("busy_start_held", bus.comp_start, 1);
        check("busy_ptr_fixed", bus.comp_A, v.a);
      end
      if (seen_bd) begin
        check("cfg_ready_after_batch", bus.cfg_ready, 1);
        check("batch_done_one_cycle", bus.batch_done, 0);
        fin = 1;
      end else begin
        if (bus.comp_start && !bus.comp_busy) begin
          check("arg_A", bus.comp_A, v.a + v.s * 64'(issued));
          check("arg_x", bus.comp_x, v.x + v.s * 64'(issued));
          check("arg_y", bus.comp_y_out, v.y + v.s * 64'(issued));
          last_a = bus.comp_A;
          st_q.push_back(cyc);
          lat_q.push_back(int'($urandom_range(v.lat_hi, v.lat_lo)));
          issued++;
        end
        if (bus.comp_done && bus.comp_stall) stall_seen = 1;
        if (bus.comp_done && !bus.comp_stall) begin
          want.index   = REC_IDX_W'(returned);
          want.latency = REC_LAT_W'(cyc - st_q.pop_front());
          void'(lat_q.pop_front());
          exp_q.push_back(want);
          returned++;
        end
        if (st_q.size() > max_out) max_out = st_q.size();
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_record", 1, 0);
          end else begin
            want = exp_q.pop_front();
            check("res_index", bus.res_index, want.index);
            check("res_latency", bus.res_latency, want.latency);
            if (int'(want.latency) < lat_min) lat_min = int'(want.latency);
            if (int'(want.latency) > lat_max) lat_max = int'(want.latency);
          end
          n_rec++;
        end
        if (bus.batch_done) seen_bd = 1;
      end
      @(negedge clk);
      it++;
    end
    if (!fin) check("batch_timeout", 0, 1);
    check("issued_count", issued, v.cnt);
    check("records_pending", exp_q.size(), 0);
    bus.comp_done = 1'b0;
    bus.comp_busy = 1'b0;
  endtask

  vec_t        tbl[5];
  vec_t        v;
  int          n_rec, max_out, lat_min, lat_max;
  logic [63:0] last_a;
  bit          stall_seen;

  initial begin
    tbl[0] = '{64'h1000, 64'h2000, 64'h3000, 64'h100, 1, 37, 37, 0, 0, 1, 1, 64'h1000, 37, 0};
    tbl[1] = '{64'h1000, 64'h2000, 64'h3000, 64'h100, 4, 10, 10, 0, 0, 1, 4, 64'h1300, 10, 0};
    tbl[2] = '{64'hA000, 64'hB000, 64'hC000, 64'h40, 4, 3, 3, 0, 0, 5, 4, 64'hA0C0, 0, 1};
    tbl[3] = '{64'h5000, 64'h6000, 64'h7000, 64'h10, 2, 4, 4, 0, 5, 1, 2, 64'h5010, 4, 0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FF00, 64'h0, 64'h8, 64'h80, 3, 2, 2, 0, 0, 1, 3, 64'h0, 2, 0};

    bus.cfg_valid = 0; bus.cfg_a_base = 0; bus.cfg_x_base = 0; bus.cfg_y_base = 0;
    bus.cfg_stride = 0; bus.cfg_count = 0; bus.comp_busy = 0; bus.comp_done = 0;
    bus.res_ready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("cfg_ready_after_reset", bus.cfg_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_batch(tbl[i], n_rec, last_a, max_out, lat_min, lat_max, stall_seen);
      check($sformatf("row%0d_nrec", i), n_rec, tbl[i].exp_nrec);
      check($sformatf("row%0d_last_a", i), last_a, tbl[i].exp_last_a);
      check($sformatf("row%0d_max_inflight", i), max_out <= MaxInflight, 1);
      check($sformatf("row%0d_stall", i), stall_seen, tbl[i].exp_stall);
      if (tbl[i].exp_lat != 0) begin
        check($sformatf("row%0d_lat_min", i), lat_min, tbl[i].exp_lat);
        check($sformatf("row%0d_lat_max", i), lat_max, tbl[i].exp_lat);
      end
    end

    // Zero-count batch: no starts, batch_done at accept+1, ready at accept+2.
    wait_cfg_ready("zero");
    bus.cfg_count = '0;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    check("zero_batch_done", bus.batch_done, 1);
    check("zero_no_start", bus.comp_start, 0);
    check("zero_cfg_ready_low", bus.cfg_ready, 0);
    @(negedge clk);
    check("zero_cfg_ready", bus.cfg_ready, 1);
    check("zero_batch_done_clear", bus.batch_done, 0);

    // Random batches.
    for (int i = 0; i < 6; i++) begin
      v.a = {$urandom, $urandom}; v.x = {$urandom, $urandom}; v.y = {$urandom, $urandom};
      v.s = {$urandom, $urandom};
      v.cnt = int'($urandom_range(12, 1));
      v.lat_lo = 1; v.lat_hi = int'($urandom_range(15, 1));
      v.busy_pct = 20; v.busy_hold = 0; v.ready_div = 0;
      run_batch(v, n_rec, last_a, max_out, lat_min, lat_max, stall_seen);
      check("rand_nrec", n_rec, v.cnt);
      check("rand_last_a", last_a, v.a + v.s * 64'(v.cnt - 1));
      check("rand_max_inflight", max_out <= MaxInflight, 1);
      check("rand_lat_min", lat_min >= 1, 1);
    end

    // Spurious done with nothing in flight: sticky error, no record.
    @(negedge clk);
    bus.comp_done = 1'b1;
    @(negedge clk);
    bus.comp_done = 1'b0;
    check("spurious_err", bus.err_spurious, 1);
    check("spurious_no_record", bus.res_valid, 0);
    @(negedge clk);
    check("spurious_err_sticky", bus.err_spurious, 1);
    check("spurious_no_record_later", bus.res_valid, 0);

    // Reset while draining: everything back to zero, next batch from index 0.
    wait_cfg_ready("drain");
    bus.cfg_a_base = 64'h7000; bus.cfg_x_base = 64'h8000; bus.cfg_y_base = 64'h9000;
    bus.cfg_stride = 64'h20; bus.cfg_count = CntW'(2);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_running", bus.running, 1);
    check("drain_no_start", bus.comp_start, 0);
    check("drain_ptr", bus.comp_A, 64'h7040);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    v = '{64'h100, 64'h200, 64'h300, 64'h8, 3, 5, 5, 0, 0, 1, 3, 64'h110, 5, 0};
    run_batch(v, n_rec, last_a, max_out, lat_min, lat_max, stall_seen);
    check("post_reset_nrec", n_rec, v.exp_nrec);
    check("post_reset_last_a", last_a, v.exp_last_a);
    check("post_reset_lat", lat_max, v.exp_lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atax_launcher.md
# atax_launcher

Host-side sequencer directly upstream of the `atax` HLS component. It accepts one batch descriptor, then issues `cfg_count` invocations of `atax` through the component's call interface. Each invocation k receives argument pointers base + k·stride. The block consumes `atax` return handshakes and emits one result record per invocation carrying the measured cycle latency. It sits between the host CSR/DMA front end and the component's call/return ports.

## Interface
- `MAX_INFLIGHT`, default 2: maximum accepted-but-not-returned invocations, range 1..8.
- `CNT_W`, default 16: width of the invocation count and index.
- `LAT_W`, default 32: width of the cycle counter and latency.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: batch descriptor valid.
- `cfg_ready` out 1: high only in IDLE.
- `cfg_a_base` in 64: base pointer for argument A.
- `cfg_x_base` in 64: base pointer for argument x.
- `cfg_y_base` in 64: base pointer for argument y_out.
- `cfg_stride` in 64: byte offset added per invocation to all three pointers.
- `cfg_count` in CNT_W: number of invocations in the batch.
- `comp_start` out 1: drives `atax` start.
- `comp_busy` in 1: from `atax` busy; start is not accepted while high.
- `comp_A` out 64: drives `atax` argument A.
- `comp_x` out 64: drives `atax` argument x.
- `comp_y_out` out 64: drives `atax` argument y_out.
- `comp_done` in 1: from `atax` done.
- `comp_stall` out 1: drives `atax` return stall.
- `res_valid` out 1: result record valid.
- `res_ready` in 1: result record accepted downstream.
- `res_index` out CNT_W: invocation number of the record.
- `res_latency` out LAT_W: measured cycles for that invocation.
- `running` out 1: high while not in IDLE.
- `batch_done` out 1: one-cycle pulse at batch end.
- `err_spurious` out 1: sticky; set by a done with nothing in flight.

## Operation
- FSM states:
  - IDLE: cfg accepted on `cfg_valid && cfg_ready`. All cfg fields are latched and issued, returned and in-flight counts are cleared. The next state is ISSUE, or DONE if `cfg_count==0`.
  - ISSUE: `comp_start` = (issued < count) && (inflight < MAX_INFLIGHT). Goes to DRAIN when issued == count.
  - DRAIN: no starts. Goes to DONE when returned == count and `res_valid==0`.
  - DONE: `batch_done`=1 for exactly one cycle, then IDLE.
- Start accept: `comp_start && !comp_busy`. On accept:
  - the pointer registers advance by `cfg_stride` (64-bit wrap-around);
  - issued and inflight increment;
  - the free-running cycle counter is pushed into the timestamp FIFO.
- Argument outputs are registered and change only on an accept.
- Invocation k (0-based) receives A = a_base + k·stride. x and y_out follow the same rule with their own bases.
- Result register is a single entry. `comp_stall = res_valid && !res_ready`, combinationally.
- Done accept: `comp_done && !comp_stall && inflight>0`. On accept:
  - the timestamp is popped from the FIFO;
  - `res_latency` = cycle counter − timestamp, modulo 2^LAT_W;
  - `res_index` = returned count, which then increments;
  - `res_valid` is set and inflight decrements.
- Returns are in order: the component completes invocations FIFO.
- `res_valid` clears on `res_ready`, unless a new done is accepted in the same cycle (back-to-back allowed).
- Simultaneous start accept and done accept: inflight is unchanged, and the FIFO pushes and pops in the same cycle.
- Done with inflight==0: ignored (no record), and `err_spurious` is set. Only reset clears it.
- `cfg_valid` outside IDLE is ignored (`cfg_ready`=0).

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters are 0. `cfg_ready` becomes 1 on the first cycle after reset deasserts.
- Cfg accept at cycle t: `comp_start` is first high at t+1 with argument k=0.
- Done accept at cycle t: `res_valid` is high at t+1.
- Latency is measured from the start-accept edge to the done-accept edge. Minimum reportable latency is 1.
- Last `res_ready` handshake at cycle t with returned==count: DONE at t+1, `batch_done` at t+1, IDLE (`cfg_ready`=1) at t+2.
- Reset mid-batch: returns to IDLE next cycle and discards the FIFO, the record and the counts. `atax` shares `reset`.

## Structure
- Package `atax_launcher_pkg`:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - pointer width constant (64);
  - result record struct {index, latency}.
- One sub-module, `atax_ts_fifo`: a MAX_INFLIGHT-deep, LAT_W-wide synchronous FIFO with simultaneous push/pop and full/empty flags. Full gates `comp_start`.

## Test plan
- **Single invocation.** Cfg: a_base=0x1000, x_base=0x2000, y_base=0x3000, stride=0x100, count=1. `comp_busy`=0, done 37 cycles after accept.
  - Required: A/x/y_out = 0x1000/0x2000/0x3000, one record {0, 37}, then `batch_done`.
- **Pipelined batch.** count=4, MAX_INFLIGHT=2, component returns after 10 cycles.
  - Required: never more than 2 outstanding; invocation 3 gets A=0x1300.
  - Required: records have indices 0..3, each with latency 10.
- **Backpressure.** `res_ready`=0 with a record pending when `comp_done` rises.
  - Required: `comp_stall`=1 and the done is held until `res_ready`=1.
  - Required: the second record does not overwrite the first, and no record is lost.
- **Zero count.** count=0.
  - Required: no `comp_start`; `batch_done` at accept+1; `cfg_ready` again at accept+2.
- **Busy and spurious done.** Hold `comp_busy`=1 for 5 cycles; issue `comp_done` while inflight=0.
  - Required: pointers stay fixed until busy drops.
  - Required: `err_spurious`=1 and no record is produced.
- **Reset mid-DRAIN.**
  - Required: all outputs 0 next cycle; a new cfg restarts from index 0.
